// File: rtl/sar_search.sv
// Successive-approximation search controller: walks a trial word MSB-first against an
// external comparator and reports the recovered value, with timeout and bad-code abort.
module sar_search #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [WIDTH-1:0] trial_o,
  output logic             trial_vld_o,
  input  logic             cmp_vld_i,
  input  logic [2:0]       cmp_res_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o,
  output logic [7:0]       led_o
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASK    = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  logic [1:0]        state_q,     state_d;
  logic [WIDTH-1:0]  acc_q,       acc_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
  logic [WIDTH-1:0]  trial_q,     trial_d;
  logic              trial_vld_q, trial_vld_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              found_q,     found_d;
  logic              err_q,       err_d;
  logic [WIDTH-1:0]  result_q,    result_d;

  logic             res_valid;
  logic             finish;
  logic [WIDTH-1:0] bit_cur;
  logic [WIDTH-1:0] bit_next;
  logic [WIDTH-1:0] acc_next;

  // Only the three one-hot codes are meaningful; anything else aborts the search.
  assign res_valid = (cmp_res_i == RES_GT) || (cmp_res_i == RES_LT) || (cmp_res_i == RES_EQ);
  assign bit_cur   = WIDTH'(1) << idx_q;
  assign bit_next  = WIDTH'(1) << (idx_q - IDX_W'(1));
  assign acc_next  = (cmp_res_i == RES_GT) ? (acc_q | bit_cur) : acc_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves one
    // unassigned; without these defaults synthesis would infer latches.
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    trial_d     = trial_q;
    trial_vld_d = trial_vld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    found_d     = found_q;
    err_d       = err_q;
    result_d    = result_q;
    finish      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_ASK;
          acc_d       = '0;
          idx_d       = IDX_W'(WIDTH - 1);
          tcnt_d      = '0;
          found_d     = 1'b0;
          err_d       = 1'b0;
          trial_d     = WIDTH'(1) << (WIDTH - 1);
          trial_vld_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_ASK, ST_VERIFY: begin
        if (cmp_vld_i) begin
          tcnt_d = '0;
          if (!res_valid) begin
            err_d    = 1'b1;
            result_d = acc_q;
            finish   = 1'b1;
          end else if (state_q == ST_ASK) begin
            if (cmp_res_i == RES_EQ) begin
              result_d = trial_q;
              found_d  = 1'b1;
              finish   = 1'b1;
            end else begin
              acc_d = acc_next;
              if (idx_q == '0) begin
                state_d = ST_VERIFY;
                trial_d = acc_next;
              end else begin
                idx_d   = idx_q - IDX_W'(1);
                trial_d = acc_next | bit_next;
              end
            end
          end else begin
            // A non-equal answer on the final confirm means the comparator contradicted itself.
            result_d = acc_q;
            found_d  = (cmp_res_i == RES_EQ);
            err_d    = (cmp_res_i != RES_EQ);
            finish   = 1'b1;
          end
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          result_d = acc_q;
          finish   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      trial_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      trial_q     <= '0;
      trial_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      trial_q     <= trial_d;
      trial_vld_q <= trial_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      err_q       <= err_d;
      result_q    <= result_d;
    end
  end

  assign trial_o     = trial_q;
  assign trial_vld_o = trial_vld_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign found_o     = found_q;
  assign err_o       = err_q;
  assign result_o    = result_q;

  // Board LEDs: status in the top two bits, value right-aligned below them.
  generate
    if (WIDTH >= 6) begin : g_led_full
      assign led_o = {err_q, found_q, result_q[5:0]};
    end else begin : g_led_pad
      assign led_o = {err_q, found_q, {(6 - WIDTH){1'b0}}, result_q};
    end
  endgenerate

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a behavioural comparator responder plus a scoreboard of
// expected trials and search outcomes built from an independent search model.
module tb_sar_search;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;

  typedef enum int {M_NORMAL, M_NEVER, M_BAD} mode_e;

  typedef struct {
    logic [3:0] result;
    logic       found;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [3:0] trial_o;
  logic       trial_vld_o;
  logic       cmp_vld_i;
  logic [2:0] cmp_res_i;
  logic       busy_o;
  logic       done_o;
  logic       found_o;
  logic       err_o;
  logic [3:0] result_o;
  logic [7:0] led_o;

  int total;
  int bad;

  logic [3:0] a_val;
  int         rsp_delay;
  mode_e      rsp_mode;
  int         wait_cnt;

  exp_t       exp_q[$];
  logic [3:0] exp_trials[$];

  sar_search #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .trial_o     (trial_o),
    .trial_vld_o (trial_vld_o),
    .cmp_vld_i   (cmp_vld_i),
    .cmp_res_i   (cmp_res_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .found_o     (found_o),
    .err_o       (err_o),
    .result_o    (result_o),
    .led_o       (led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] compare(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      return 3'b100;
    else if (a < b) return 3'b010;
    else            return 3'b001;
  endfunction

  // Reference search: MSB-first bisection, counting trials to predict latency.
  function automatic void model(input logic [3:0] a, input int delay, input mode_e m);
    exp_t       e;
    logic [3:0] acc;
    logic [3:0] t;
    int         k;
    e.result = 4'd0;
    e.found  = 1'b0;
    e.err    = 1'b0;
    e.lat    = 0;
    case (m)
      M_NEVER: begin
        e.err = 1'b1;
        e.lat = TIMEOUT + 1;
      end
      M_BAD: begin
        exp_trials.push_back(4'd8);
        e.err = 1'b1;
        e.lat = delay + 2;
      end
      default: begin
        acc = 4'd0;
        k   = 0;
        for (int b = 3; b >= 0; b--) begin
          t = acc | (4'd1 << b);
          exp_trials.push_back(t);
          k++;
          if (t == a) begin
            e.found  = 1'b1;
            e.result = t;
            break;
          end
          if (a > t) acc = t;
        end
        if (!e.found) begin
          exp_trials.push_back(acc);
          k++;
          e.found  = (acc == a);
          e.err    = (acc != a);
          e.result = acc;
        end
        e.lat = k * (delay + 1) + 1;
      end
    endcase
    exp_q.push_back(e);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_trial"},     32'(trial_o),     32'd0);
    check({tag, "_trial_vld"}, 32'(trial_vld_o), 32'd0);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_done"},      32'(done_o),      32'd0);
    check({tag, "_found"},     32'(found_o),     32'd0);
    check({tag, "_err"},       32'(err_o),       32'd0);
    check({tag, "_result"},    32'(result_o),    32'd0);
    check({tag, "_led"},       32'(led_o),       32'd0);
  endtask

  // poke: cycle number in which a stray start is driven mid-search (0 = none).
  task automatic run_search(input string tag, input int poke);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n       = 1;
    seen    = 1'b0;
    check({tag, "_busy_run"}, 32'(busy_o),      32'd1);
    check({tag, "_vld_run"},  32'(trial_vld_o), 32'd1);
    while (!seen && n < 200) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        start_i = (n == poke);
        @(negedge clk);
        n++;
      end
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen),        32'd1);
    check({tag, "_latency"},   32'(n),           32'(e.lat));
    check({tag, "_found"},     32'(found_o),     32'(e.found));
    check({tag, "_err"},       32'(err_o),       32'(e.err));
    check({tag, "_result"},    32'(result_o),    32'(e.result));
    check({tag, "_led"},       32'(led_o),       32'({e.err, e.found, 2'b00, e.result}));
    check({tag, "_busy_done"}, 32'(busy_o),      32'd0);
    check({tag, "_vld_done"},  32'(trial_vld_o), 32'd0);
    // start during the done cycle must not launch a new search
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_done_1cyc"},   32'(done_o),      32'd0);
    check({tag, "_busy_after"},  32'(busy_o),      32'd0);
    check({tag, "_vld_after"},   32'(trial_vld_o), 32'd0);
    check({tag, "_found_hold"},  32'(found_o),     32'(e.found));
    check({tag, "_result_hold"}, 32'(result_o),    32'(e.result));
  endtask

  task automatic search(input string tag, input logic [3:0] a, input int delay,
                        input mode_e m, input int poke);
    a_val     = a;
    rsp_delay = delay;
    rsp_mode  = m;
    model(a, delay, m);
    run_search(tag, poke);
  endtask

  initial begin
    bit done_seen;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    cmp_vld_i = 1'b0;
    cmp_res_i = 3'b000;
    a_val     = 4'd0;
    rsp_delay = 0;
    rsp_mode  = M_NORMAL;
    wait_cnt  = 0;

    // Comparator responder: answers each held trial after rsp_delay idle cycles.
    fork
      forever begin
        @(negedge clk);
        if (trial_vld_o === 1'b1 && rsp_mode != M_NEVER) begin
          if (wait_cnt == rsp_delay) begin
            cmp_vld_i = 1'b1;
            cmp_res_i = (rsp_mode == M_BAD) ? 3'b110 : compare(a_val, trial_o);
            check("trial_expected", 32'(exp_trials.size() != 0), 32'd1);
            if (exp_trials.size() != 0) check("trial_word", 32'(trial_o), 32'(exp_trials.pop_front()));
            wait_cnt = 0;
          end else begin
            cmp_vld_i = 1'b0;
            wait_cnt++;
          end
        end else begin
          cmp_vld_i = 1'b0;
          wait_cnt  = 0;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    search("a10_zw",  4'd10, 0, M_NORMAL, 0);
    search("a0_zw",   4'd0,  0, M_NORMAL, 0);
    search("a15_zw",  4'd15, 0, M_NORMAL, 0);
    search("timeout", 4'd5,  0, M_NEVER,  0);
    search("badcode", 4'd5,  0, M_BAD,    0);

    // Reset in the middle of the second trial of a slow search.
    a_val     = 4'd10;
    rsp_delay = 3;
    rsp_mode  = M_NORMAL;
    exp_trials.push_back(4'd8);
    done_seen = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) begin
      if (done_o === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_trial2", 32'(trial_o), 32'd12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midrst");
    check("midrst_trials_used", 32'(exp_trials.size()), 32'd0);
    repeat (3) begin
      if (done_o === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

    search("a10_slow", 4'd10, 3, M_NORMAL, 3);

    for (int v = 0; v < 16; v++) begin
      search("sweep", 4'(v), v % 3, M_NORMAL, 0);
    end

    check("trials_drained", 32'(exp_trials.size()), 32'd0);
    check("results_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
